// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR output stream buffer.
package fir_pkg;

    localparam int unsigned P_DATA_WIDTH = 32;
    localparam int unsigned P_DEPTH      = 8;
    localparam int unsigned P_CNT_WIDTH  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fir_stream_out_buf_if.sv
// AXI-Stream style beat channel (valid/ready/data/last) with master/slave views.
interface fir_stream_out_buf_if
    import fir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = P_DATA_WIDTH
);

    logic                  tvalid;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tready;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/fir_sync_fifo.sv
// Single-clock FIFO with occupancy count; head entry is read combinationally.
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter  int unsigned WIDTH = P_DATA_WIDTH + 1,
    parameter  int unsigned DEPTH = P_DEPTH,
    localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fir_stream_out_buf.sv
// FIR output buffer: FIFO between FIR core and consumer, sample counting and done flag.
// Optional FIR_OUT_TLAST_CHECK_EN: tlast generated from data_length and input tlast checked.
module fir_stream_out_buf
    import fir_pkg::*;
#(
    parameter  int unsigned pDATA_WIDTH = P_DATA_WIDTH,
    parameter  int unsigned pDEPTH      = P_DEPTH,
    parameter  int unsigned pCNT_WIDTH  = P_CNT_WIDTH,
    localparam int unsigned LW          = $clog2(pDEPTH) + 1
) (
    input  logic                  axis_clk,
    input  logic                  axis_rst_n,
    input  logic                  start,
    input  logic                  clear,
    input  logic [pCNT_WIDTH-1:0] data_length,
    fir_stream_out_buf_if.slave   ss,
    fir_stream_out_buf_if.master  sm,
    output logic [LW-1:0]         level,
    output logic                  done,
    output logic                  tlast_err
);

    state_t                  state_q;
    state_t                  state_d;
    logic [pCNT_WIDTH-1:0]   in_cnt;
    logic [pCNT_WIDTH-1:0]   out_cnt;
    logic [pDATA_WIDTH:0]    head;
    logic                    store_last;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic                    run;
    logic                    start_ok;
    logic                    len_zero;
    logic                    last_pop;

    assign run      = (state_q == RUN);
    assign start_ok = start & ~clear & (state_q != RUN);
    assign len_zero = (data_length == '0);
    assign push     = ss.tvalid & ss.tready;
    assign pop      = sm.tvalid & sm.tready;
    assign last_pop = run & pop & sm.tlast;

`ifdef FIR_OUT_TLAST_CHECK_EN
    logic [pCNT_WIDTH-1:0] len_q;
    logic                  exp_last;

    assign exp_last   = (in_cnt == len_q - pCNT_WIDTH'(1));
    assign store_last = exp_last;
    // Once the programmed count has been accepted, further beats are refused.
    assign ss.tready  = run & ~full & (in_cnt != len_q);

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n || clear) begin
            len_q     <= '0;
            tlast_err <= 1'b0;
        end else if (start_ok) begin
            len_q     <= data_length;
            tlast_err <= 1'b0;
        end else if (push && (ss.tlast != exp_last)) begin
            tlast_err <= 1'b1;
        end
    end
`else
    assign store_last = ss.tlast;
    assign ss.tready  = run & ~full;
    assign tlast_err  = 1'b0;
`endif

    fir_sync_fifo #(
        .WIDTH (pDATA_WIDTH + 1),
        .DEPTH (pDEPTH)
    ) u_fifo (
        .clk   (axis_clk),
        .rst_n (axis_rst_n),
        .flush (clear),
        .push  (push),
        .pop   (pop),
        .wdata ({store_last, ss.tdata}),
        .rdata (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // Output is forced to zero while empty so reset/flush presents a clean bus.
    assign sm.tvalid = ~empty;
    assign sm.tdata  = empty ? '0 : head[pDATA_WIDTH-1:0];
    assign sm.tlast  = ~empty & head[pDATA_WIDTH];

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) state_q <= IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (start) state_d = len_zero ? DONE : RUN;
                RUN:        if (last_pop) state_d = DONE;
                default:    state_d = IDLE;
            endcase
        end
    end

    // Sample counters and sticky done flag.
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n || clear) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            done    <= 1'b0;
        end else if (start_ok) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            done    <= len_zero;
        end else begin
            if (push)     in_cnt  <= in_cnt + pCNT_WIDTH'(1);
            if (pop)      out_cnt <= out_cnt + pCNT_WIDTH'(1);
            if (last_pop) done    <= 1'b1;
        end
    end

endmodule
